// File: rtl/byte_packer.sv
// byte_packer: packs a serial byte stream into SIZE-byte words
// with a one-word output buffer and partial-word flush.
module byte_packer #(
  parameter int SIZE      = 2,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [7:0]                  in_byte,
  output logic                        in_ready,
  input  logic                        flush,
  output logic                        out_valid,
  output logic [SIZE*8-1:0]           out_word,
  output logic [$clog2(SIZE+1)-1:0]   out_count,
  input  logic                        out_ready,
  output logic                        busy
);

  localparam int W  = SIZE * 8;
  localparam int CW = $clog2(SIZE + 1);

  logic [W-1:0]  r_asm;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_out_word;
  logic [CW-1:0] r_out_count;
  logic          r_out_valid;
  logic          r_flush_pend;

  logic          w_slot_free;
  logic          w_room;
  logic          w_last;
  logic          w_acc;
  logic [W-1:0]  w_merged;
  logic [CW-1:0] w_bytes;
  logic          w_full;
  logic          w_flush_go;
  logic          w_load;

  generate
    if (SIZE == 1) begin : g_one
      assign w_room = 1'b0;
    end else begin : g_many
      assign w_room = (r_cnt < CW'(SIZE - 1));
    end
  endgenerate

  assign w_last      = (r_cnt == CW'(SIZE - 1));
  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = !r_flush_pend && (w_room || w_slot_free);
  assign w_acc       = in_valid && in_ready;
  assign w_bytes     = r_cnt + CW'(w_acc);
  assign w_full      = w_acc && w_last;
  assign w_flush_go  = (flush || r_flush_pend) && w_slot_free;
  assign w_load      = w_full || (w_flush_go && (w_bytes != '0));

  // Merge the incoming byte into the lane selected by the current count
  always_comb begin
    w_merged = r_asm;
    if (w_acc) begin
      for (int k = 0; k < SIZE; k++) begin
        if (r_cnt == CW'(k)) begin
          if (MSB_FIRST)
            w_merged[(SIZE-1-k)*8 +: 8] = in_byte;
          else
            w_merged[k*8 +: 8] = in_byte;
        end
      end
    end
  end

  // Assembly register, output buffer and pending-flush tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_asm        <= '0;
      r_cnt        <= '0;
      r_out_word   <= '0;
      r_out_count  <= '0;
      r_out_valid  <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_word  <= w_merged;
        r_out_count <= w_bytes;
        r_out_valid <= 1'b1;
        r_asm       <= '0;
        r_cnt       <= '0;
      end else begin
        if (r_out_valid && out_ready)
          r_out_valid <= 1'b0;
        if (w_acc) begin
          r_asm <= w_merged;
          r_cnt <= r_cnt + CW'(1);
        end
      end
      if (w_flush_go)
        r_flush_pend <= 1'b0;
      else if (flush)
        r_flush_pend <= 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_word  = r_out_word;
  assign out_count = r_out_count;
  assign busy      = (r_cnt != '0) || r_out_valid || r_flush_pend;

endmodule

// File: tb/tb_byte_packer.sv
// tb_byte_packer: directed checks of byte_packer across
// SIZE=1/2/4 and both lane orders.
module tb_byte_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // shared stimulus for the SIZE=2 (both orders) and SIZE=1 units
  logic       a_iv = 1'b0;
  logic [7:0] a_ib = 8'h00;
  logic       a_fl = 1'b0;
  logic       a_ordy = 1'b1;

  logic        l_rdy, l_ov, l_busy;
  logic [15:0] l_w;
  logic [1:0]  l_c;
  logic        m_rdy, m_ov, m_busy;
  logic [15:0] m_w;
  logic [1:0]  m_c;
  logic        s_rdy, s_ov, s_busy;
  logic [7:0]  s_w;
  logic [0:0]  s_c;

  // SIZE=4 unit
  logic       b_iv = 1'b0;
  logic [7:0] b_ib = 8'h00;
  logic       b_fl = 1'b0;
  logic       b_ordy = 1'b1;
  logic        q_rdy, q_ov, q_busy;
  logic [31:0] q_w;
  logic [2:0]  q_c;

  byte_packer #(.SIZE(2), .MSB_FIRST(1'b0)) u_l (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_byte(a_ib),
    .in_ready(l_rdy), .flush(a_fl), .out_valid(l_ov),
    .out_word(l_w), .out_count(l_c), .out_ready(a_ordy),
    .busy(l_busy));

  byte_packer #(.SIZE(2), .MSB_FIRST(1'b1)) u_m (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_byte(a_ib),
    .in_ready(m_rdy), .flush(a_fl), .out_valid(m_ov),
    .out_word(m_w), .out_count(m_c), .out_ready(a_ordy),
    .busy(m_busy));

  byte_packer #(.SIZE(1), .MSB_FIRST(1'b0)) u_s (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_byte(a_ib),
    .in_ready(s_rdy), .flush(a_fl), .out_valid(s_ov),
    .out_word(s_w), .out_count(s_c), .out_ready(a_ordy),
    .busy(s_busy));

  byte_packer #(.SIZE(4), .MSB_FIRST(1'b0)) u_q (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_byte(b_ib),
    .in_ready(q_rdy), .flush(b_fl), .out_valid(q_ov),
    .out_word(q_w), .out_count(q_c), .out_ready(b_ordy),
    .busy(q_busy));

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // drive SIZE=4 inputs, check in_ready before the edge,
  // then advance one clock and settle
  task automatic b_step(input logic iv, input logic [7:0] d,
                        input logic fl, input logic ordy,
                        input logic exp_rdy, input string nm);
    b_iv = iv; b_ib = d; b_fl = fl; b_ordy = ordy;
    #1;
    chk({nm, ".in_ready"}, 32'(q_rdy), 32'(exp_rdy));
    @(posedge clk); #1;
    b_iv = 1'b0; b_fl = 1'b0;
  endtask

  typedef struct {
    logic        iv;
    logic [7:0]  ib;
    logic        fl;
    logic        rdy;
    logic        ov;
    logic [15:0] wl;
    logic [15:0] wm;
    logic [1:0]  cnt;
    logic        ov1;
    logic [7:0]  w1;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 2'd0, 1'b1, 8'h11};
    vt[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 16'h2211, 16'h1122, 2'd2, 1'b1, 8'h22};
    vt[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 2'd0, 1'b1, 8'h33};
    vt[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 16'h4433, 16'h3344, 2'd2, 1'b1, 8'h44};
    vt[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 2'd0, 1'b0, 8'h00};
    vt[5] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 2'd0, 1'b1, 8'h55};
    vt[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'h0055, 16'h5500, 2'd1, 1'b0, 8'h00};
    vt[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 2'd0, 1'b0, 8'h00};

    // reset state
    #12;
    chk("rst.l_ov", 32'(l_ov), 32'd0);
    chk("rst.l_rdy", 32'(l_rdy), 32'd1);
    chk("rst.l_busy", 32'(l_busy), 32'd0);
    chk("rst.q_ov", 32'(q_ov), 32'd0);
    chk("rst.q_rdy", 32'(q_rdy), 32'd1);
    chk("rst.q_busy", 32'(q_busy), 32'd0);
    chk("rst.q_w", q_w, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // table-driven: SIZE=2 both orders and SIZE=1
    for (int i = 0; i < 8; i++) begin
      a_iv = vt[i].iv; a_ib = vt[i].ib; a_fl = vt[i].fl;
      #1;
      chk($sformatf("v%0d.l_rdy", i), 32'(l_rdy), 32'(vt[i].rdy));
      chk($sformatf("v%0d.s_rdy", i), 32'(s_rdy), 32'(vt[i].rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d.l_ov", i), 32'(l_ov), 32'(vt[i].ov));
      chk($sformatf("v%0d.m_ov", i), 32'(m_ov), 32'(vt[i].ov));
      if (vt[i].ov) begin
        chk($sformatf("v%0d.l_w", i), 32'(l_w), 32'(vt[i].wl));
        chk($sformatf("v%0d.m_w", i), 32'(m_w), 32'(vt[i].wm));
        chk($sformatf("v%0d.l_c", i), 32'(l_c), 32'(vt[i].cnt));
      end
      chk($sformatf("v%0d.s_ov", i), 32'(s_ov), 32'(vt[i].ov1));
      if (vt[i].ov1) begin
        chk($sformatf("v%0d.s_w", i), 32'(s_w), 32'(vt[i].w1));
        chk($sformatf("v%0d.s_c", i), 32'(s_c), 32'd1);
      end
    end
    a_iv = 1'b0; a_fl = 1'b0;

    // backpressure, SIZE=4
    b_step(1, 8'h01, 0, 0, 1, "bp01");
    b_step(1, 8'h02, 0, 0, 1, "bp02");
    b_step(1, 8'h03, 0, 0, 1, "bp03");
    b_step(1, 8'h04, 0, 0, 1, "bp04");
    chk("bp.ov", 32'(q_ov), 32'd1);
    chk("bp.w", q_w, 32'h04030201);
    chk("bp.c", 32'(q_c), 32'd4);
    b_step(1, 8'h05, 0, 0, 1, "bp05");
    b_step(1, 8'h06, 0, 0, 1, "bp06");
    b_step(1, 8'h07, 0, 0, 1, "bp07");
    b_step(1, 8'h08, 0, 0, 0, "bp08a");
    chk("bp.hold1", q_w, 32'h04030201);
    b_step(1, 8'h08, 0, 0, 0, "bp08b");
    chk("bp.hold2", q_w, 32'h04030201);
    chk("bp.hold_ov", 32'(q_ov), 32'd1);
    b_step(1, 8'h08, 0, 1, 1, "bp08c");
    chk("bp.w2_ov", 32'(q_ov), 32'd1);
    chk("bp.w2", q_w, 32'h08070605);
    b_step(0, 8'h00, 0, 1, 1, "bpidle");
    chk("bp.drain", 32'(q_ov), 32'd0);

    // partial flush and empty flush
    b_step(1, 8'hAB, 0, 1, 1, "pfab");
    b_step(0, 8'h00, 1, 1, 1, "pffl");
    chk("pf.ov", 32'(q_ov), 32'd1);
    chk("pf.w", q_w, 32'h000000AB);
    chk("pf.c", 32'(q_c), 32'd1);
    b_step(0, 8'h00, 0, 1, 1, "pfidle");
    chk("pf.drain", 32'(q_ov), 32'd0);
    b_step(0, 8'h00, 1, 1, 1, "pfempty");
    chk("pf.empty_ov", 32'(q_ov), 32'd0);
    chk("pf.empty_busy", 32'(q_busy), 32'd0);

    // pending flush behind a stalled word
    b_step(1, 8'hA1, 0, 0, 1, "pnA1");
    b_step(1, 8'hA2, 0, 0, 1, "pnA2");
    b_step(1, 8'hA3, 0, 0, 1, "pnA3");
    b_step(1, 8'hA4, 0, 0, 1, "pnA4");
    b_step(1, 8'hCD, 0, 0, 1, "pnCD");
    b_step(0, 8'h00, 1, 0, 1, "pnfl");
    b_iv = 1'b1; b_ib = 8'hEE;
    #1;
    chk("pn.rdy", 32'(q_rdy), 32'd0);
    chk("pn.busy", 32'(q_busy), 32'd1);
    chk("pn.old", q_w, 32'hA4A3A2A1);
    b_step(0, 8'h00, 0, 1, 0, "pnrel");
    chk("pn.ov", 32'(q_ov), 32'd1);
    chk("pn.w", q_w, 32'h000000CD);
    chk("pn.c", 32'(q_c), 32'd1);
    #1;
    chk("pn.rdy2", 32'(q_rdy), 32'd1);
    b_step(0, 8'h00, 0, 1, 1, "pnidle");
    chk("pn.drain", 32'(q_ov), 32'd0);
    chk("pn.busy2", 32'(q_busy), 32'd0);

    // asynchronous reset mid-word
    b_step(1, 8'hE1, 0, 0, 1, "rsE1");
    b_step(1, 8'hE2, 0, 0, 1, "rsE2");
    b_step(1, 8'hE3, 0, 0, 1, "rsE3");
    b_step(1, 8'hE4, 0, 0, 1, "rsE4");
    b_step(1, 8'hF1, 0, 0, 1, "rsF1");
    b_step(1, 8'hF2, 0, 0, 1, "rsF2");
    b_step(1, 8'hF3, 0, 0, 1, "rsF3");
    #2;
    rst = 1'b1;
    #1;
    chk("rs.ov", 32'(q_ov), 32'd0);
    chk("rs.w", q_w, 32'd0);
    chk("rs.c", 32'(q_c), 32'd0);
    chk("rs.busy", 32'(q_busy), 32'd0);
    chk("rs.rdy", 32'(q_rdy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    b_step(1, 8'h10, 0, 1, 1, "rs10");
    b_step(1, 8'h11, 0, 1, 1, "rs11");
    b_step(1, 8'h12, 0, 1, 1, "rs12");
    b_step(1, 8'h13, 0, 1, 1, "rs13");
    chk("rs.ov2", 32'(q_ov), 32'd1);
    chk("rs.w2", q_w, 32'h13121110);
    chk("rs.c2", 32'(q_c), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/byte_packer.md
Name: byte_packer

Overview:
Downstream of the byte shift register. Collects the serial byte stream into SIZE-byte words and hands them to the systolic array input staging over a valid/ready handshake. Lane order matches the shift register's shift-out order, so a packed word loaded back as parallel input reproduces the original stream. It has a one-word output buffer so assembly can continue while the consumer stalls, and supports flushing a partial word.

Parameters:
SIZE, 2, bytes per output word (>=1)
MSB_FIRST, 0, 0: first byte received lands in bits [7:0]; 1: first byte lands in the top byte [SIZE*8-1 -: 8]

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_byte is valid this cycle
in_byte  input  8  incoming stream byte
in_ready  output  1  block accepts in_byte this cycle
flush  input  1  single-cycle request to emit the current partial word
out_valid  output  1  out_word/out_count valid
out_word  output  SIZE*8  packed word; unfilled lanes are zero
out_count  output  $clog2(SIZE+1)  number of valid bytes in out_word (1..SIZE)
out_ready  input  1  consumer takes the word this cycle
busy  output  1  high when assembly count != 0, out_valid is high, or a flush is pending

Behaviour:
- Reset (async, rst=1): assembly register, count, out_word, out_count, out_valid and flush_pend all go to 0. in_ready then reads 1 and busy reads 0. A reset mid-word discards the partial word and any pending flush.
- State: assembly register asm[SIZE*8], count cnt in 0..SIZE-1, output register (out_word, out_count, out_valid), flag flush_pend.
- slot_free = !out_valid || out_ready. This is combinational, so out_ready reaches in_ready with no register in between.
- in_ready = !flush_pend && (cnt < SIZE-1 || slot_free). For SIZE=1 this reduces to !flush_pend && slot_free.
- Accept = in_valid && in_ready.
- Lane for byte index k = cnt:
  - MSB_FIRST=0: bits [8k+7:8k].
  - MSB_FIRST=1: bits [(SIZE-k)*8-1 -: 8].
- Accept with cnt < SIZE-1: write the byte into its lane and increment cnt. No output change.
- Accept with cnt == SIZE-1 (word completes):
  - Next cycle: out_word = asm with the byte merged, out_count = SIZE, out_valid = 1.
  - asm and cnt clear to 0.
  - Latency is one cycle from the last byte to out_valid.
- Output hold: while out_valid && !out_ready, out_word and out_count are stable.
- Drain: on out_ready && out_valid with no new word loading, out_valid goes to 0 next cycle. A drain and a load in the same cycle are back-to-back with no bubble; full rate is one word every SIZE cycles.
- Flush:
  - A flush pulse sets flush_pend, unless it is honoured in the same cycle.
  - Honoured when (flush || flush_pend) && slot_free.
  - A byte accepted in that same cycle is merged first.
  - If the resulting byte count is 0, the flush is a no-op and flush_pend clears.
  - Otherwise the output register loads asm with the merged byte, zero padding and out_count = bytes; asm, cnt and flush_pend clear.
  - While flush_pend is set, in_ready = 0, so no new bytes mix into the flushed word.
  - A flush arriving in the same cycle a word completes yields that full word with out_count = SIZE; nothing further is emitted.
  - Flush pulses while flush_pend is already set are absorbed, not queued.
- Source stability: in_byte is ignored when in_valid=0. An in_valid that is not accepted may be withdrawn.

Test Plan:
- Basic pack: SIZE=2, MSB_FIRST=0, out_ready=1. Stream 0x11, 0x22, 0x33, 0x44 back-to-back -> out_word 0x2211 then 0x4433, each out_count=2, out_valid one cycle after the 2nd/4th byte, in_ready constantly 1.
- Lane order: SIZE=2, MSB_FIRST=1, same stream -> 0x1122 then 0x3344. Also SIZE=1: each byte appears as out_word with a 1-cycle latency.
- Backpressure: SIZE=4, out_ready=0. Feed 0x01..0x08:
  - word 0x04030201 is held stable;
  - 0x05..0x07 are accepted;
  - in_ready drops with 0x08 offered and stays low until out_ready=1;
  - 0x08 is then accepted in the drain cycle and word 0x08070605 follows with no bubble.
- Partial flush: SIZE=4. Send 0xAB, then a flush pulse -> out_word 0x000000AB, out_count=1. A flush with cnt=0 produces no out_valid.
- Pending flush: SIZE=4, out_valid held by out_ready=0. Send 0xCD, flush -> in_ready=0 and busy=1. Raise out_ready -> old word drains, 0x000000CD with count 1 follows next cycle, and flush_pend clears.
- Reset mid-word: SIZE=4 after 3 bytes, assert rst asynchronously between edges -> all outputs 0 immediately. After release, bytes 0x10..0x13 give 0x13121110 with no residue.
